if_fetch_unit: RTL and testbench

- Instruction-fetch (IF) stage of the MIPS pipeline.
- Owns the fetch PC and issues requests to instruction memory over a req/ack handshake; memory latency may vary.
- Drives the instruction and PC+4 into the IF/ID pipeline register.
- Handles hazard stalls with a one-entry skid buffer, and squashes wrong-path fetches on branch/jump redirects from ID/EX.

---
 rtl/if_fetch_unit_pkg.sv | 14 +
 rtl/if_fetch_unit_if.sv | 13 +
 rtl/if_fetch_unit_skid.sv | 37 +++
 rtl/if_fetch_unit.sv | 180 ++++++++++++++++++
 tb/tb_if_fetch_unit.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared MIPS pipeline types and constants for the instruction-fetch stage.
package mips_pipe_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_e;

  localparam logic [31:0] PC_INCR   = 32'd4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
interface if_fetch_unit_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
);
  logic                   imem_req;
  logic [ADDR_WIDTH-1:0]  imem_addr;
  logic                   imem_ack;
  logic [INSTR_WIDTH-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/if_fetch_unit_skid.sv
// One-entry instruction + PC holding register used while IF/ID is stalled.
module if_skid_buffer #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_i,
  input  logic                   clear_i,
  input  logic [INSTR_WIDTH-1:0] instr_i,
  input  logic [ADDR_WIDTH-1:0]  pc_i,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0]  pc_o
);
  logic [INSTR_WIDTH-1:0] instr_q;
  logic [ADDR_WIDTH-1:0]  pc_q;

  // Entry register: clear wins over load so a squashed entry never survives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= {INSTR_WIDTH{1'b0}};
      pc_q    <= {ADDR_WIDTH{1'b0}};
    end else if (clear_i) begin
      instr_q <= {INSTR_WIDTH{1'b0}};
      pc_q    <= {ADDR_WIDTH{1'b0}};
    end else if (load_i) begin
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end else begin
      instr_q <= instr_q;
      pc_q    <= pc_q;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
endmodule

// File: rtl/if_fetch_unit.sv
// MIPS IF stage: fetch PC, imem handshake, stall skid and redirect squash.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module if_fetch_unit
  import mips_pipe_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(32'h0000_0000)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  if_fetch_unit_if.master        imem,
  output logic [ADDR_WIDTH-1:0]  pc_out,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic                   instr_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]            fetch_count,
  output logic [31:0]            bubble_count
`endif
);
  fetch_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0]  fetch_addr_q, fetch_addr_d;
  logic [ADDR_WIDTH-1:0]  pending_pc_q, pending_pc_d;
  logic [ADDR_WIDTH-1:0]  pc_out_q, pc_out_d;
  logic [INSTR_WIDTH-1:0] instr_out_q, instr_out_d;
  logic                   instr_valid_q, instr_valid_d;
  logic                   skid_load_s, skid_clear_s;
  logic [INSTR_WIDTH-1:0] skid_instr_s;
  logic [ADDR_WIDTH-1:0]  skid_pc_s;
  logic [ADDR_WIDTH-1:0]  redir_pc_s, next_addr_s;
  logic                   ack_s;

  assign ack_s       = imem.imem_ack;
  assign redir_pc_s  = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign next_addr_s = fetch_addr_q + ADDR_WIDTH'(PC_INCR);

  if_skid_buffer #(.ADDR_WIDTH(ADDR_WIDTH), .INSTR_WIDTH(INSTR_WIDTH)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .load_i  (skid_load_s),
    .clear_i (skid_clear_s),
    .instr_i (imem.imem_rdata),
    .pc_i    (next_addr_s),
    .instr_o (skid_instr_s),
    .pc_o    (skid_pc_s)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      fetch_addr_q  <= RESET_PC;
      pending_pc_q  <= {ADDR_WIDTH{1'b0}};
      pc_out_q      <= {ADDR_WIDTH{1'b0}};
      instr_out_q   <= INSTR_WIDTH'(NOP_INSTR);
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_addr_q  <= fetch_addr_d;
      pending_pc_q  <= pending_pc_d;
      pc_out_q      <= pc_out_d;
      instr_out_q   <= instr_out_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  // Next-state logic; redirect outranks ack, which outranks stall.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = REQ;
      REQ: begin
        if (redirect_valid) state_d = ack_s ? REQ : DISCARD;
        else if (ack_s)     state_d = stall ? HOLD : REQ;
        else                state_d = REQ;
      end
      HOLD: begin
        if (redirect_valid || !stall) state_d = REQ;
        else                          state_d = HOLD;
      end
      DISCARD: begin
        if (ack_s) state_d = REQ;
        else       state_d = DISCARD;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and address updates per state.
  always_comb begin
    fetch_addr_d  = fetch_addr_q;
    pending_pc_d  = pending_pc_q;
    pc_out_d      = pc_out_q;
    instr_out_d   = instr_out_q;
    instr_valid_d = instr_valid_q;
    skid_load_s   = 1'b0;
    skid_clear_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (redirect_valid) fetch_addr_d = redir_pc_s;
        else                fetch_addr_d = fetch_addr_q;
      end
      REQ: begin
        if (redirect_valid) begin
          instr_valid_d = 1'b0;
          if (ack_s) fetch_addr_d = redir_pc_s;
          else       pending_pc_d = redir_pc_s;
        end else if (ack_s) begin
          fetch_addr_d = next_addr_s;
          if (stall) begin
            skid_load_s = 1'b1;
          end else begin
            instr_out_d   = imem.imem_rdata;
            pc_out_d      = next_addr_s;
            instr_valid_d = 1'b1;
          end
        end else if (!stall) begin
          instr_valid_d = 1'b0;
        end else begin
          instr_valid_d = instr_valid_q;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          skid_clear_s  = 1'b1;
          fetch_addr_d  = redir_pc_s;
          instr_valid_d = 1'b0;
        end else if (!stall) begin
          instr_out_d   = skid_instr_s;
          pc_out_d      = skid_pc_s;
          instr_valid_d = 1'b1;
        end else begin
          instr_valid_d = instr_valid_q;
        end
      end
      DISCARD: begin
        instr_valid_d = 1'b0;
        if (redirect_valid) pending_pc_d = redir_pc_s;
        else                pending_pc_d = pending_pc_q;
        if (ack_s) fetch_addr_d = redirect_valid ? redir_pc_s : pending_pc_q;
        else       fetch_addr_d = fetch_addr_q;
      end
      default: instr_valid_d = 1'b0;
    endcase
  end

  assign imem.imem_req  = (state_q == REQ) || (state_q == DISCARD);
  assign imem.imem_addr = fetch_addr_q;
  assign pc_out         = pc_out_q;
  assign instr_out      = instr_out_q;
  assign instr_valid    = instr_valid_q;

`ifdef IF_PERF_CNT_EN
  logic        deliver_s, bubble_s;
  logic [31:0] fetch_cnt_q, bubble_cnt_q;

  assign deliver_s = instr_valid_d & ~stall & ~redirect_valid & (state_q != IDLE);
  assign bubble_s  = ~instr_valid_d & ~stall & (state_q != IDLE);

  // Saturating delivery and bubble counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      if (deliver_s && (fetch_cnt_q != 32'hFFFF_FFFF)) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      else                                             fetch_cnt_q <= fetch_cnt_q;
      if (bubble_s && (bubble_cnt_q != 32'hFFFF_FFFF)) bubble_cnt_q <= bubble_cnt_q + 32'd1;
      else                                             bubble_cnt_q <= bubble_cnt_q;
    end
  end

  assign fetch_count  = fetch_cnt_q;
  assign bubble_count = bubble_cnt_q;
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed + randomized bench for if_fetch_unit against a program-order delivery model.
module tb_if_fetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        instr_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;
`endif

  if_fetch_unit_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) imem_bus ();

  if_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (imem_bus),
    .pc_out         (pc_out),
    .instr_out      (instr_out),
    .instr_valid    (instr_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_count    (fetch_count),
    .bubble_count   (bubble_count)
`endif
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_deliv = 0;
  int          lat_cnt = 0;
  logic [31:0] exp_pc;

  // Instruction memory contents as a pure function of the word address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: drive at negedge, sample 1ns after posedge, then apply the delivery model.
  task automatic cyc(input logic st, input logic rv, input logic [31:0] rp, input logic ak);
    logic [31:0] p_pc, p_instr, p_addr;
    logic        p_valid, p_req;
    @(negedge clk);
    stall               = st;
    redirect_valid      = rv;
    redirect_pc         = rp;
    imem_bus.imem_ack   = ak;
    imem_bus.imem_rdata = ak ? memf(imem_bus.imem_addr) : $urandom;
    p_pc    = pc_out;
    p_instr = instr_out;
    p_valid = instr_valid;
    p_req   = imem_bus.imem_req;
    p_addr  = imem_bus.imem_addr;
    @(posedge clk);
    #1;
    if (p_req && !ak) begin
      chk("req_held", {31'd0, imem_bus.imem_req}, 32'd1);
      chk("addr_stable", imem_bus.imem_addr, p_addr);
    end
    if (rv) begin
      chk("squash_valid", {31'd0, instr_valid}, 32'd0);
      exp_pc = {rp[31:2], 2'b00};
    end else if (st) begin
      chk("stall_hold_valid", {31'd0, instr_valid}, {31'd0, p_valid});
      chk("stall_hold_pc", pc_out, p_pc);
      chk("stall_hold_instr", instr_out, p_instr);
    end else if (instr_valid) begin
      chk("deliver_pc", pc_out, exp_pc + 32'd4);
      chk("deliver_instr", instr_out, memf(exp_pc));
      exp_pc = exp_pc + 32'd4;
      n_deliv++;
    end
  endtask

  logic        r_ak, r_st, r_rv;
  logic [31:0] r_rp;

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = 32'd0;
    exp_pc = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr_out, 32'd0);
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_req", {31'd0, imem_bus.imem_req}, 32'd0);
    reset = 1'b0;

    // Zero-wait streaming from RESET_PC.
    cyc(1'b0, 1'b0, 32'd0, 1'b0);
    chk("first_req", {31'd0, imem_bus.imem_req}, 32'd1);
    chk("first_addr", imem_bus.imem_addr, 32'd0);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    chk("stream_addr4", imem_bus.imem_addr, 32'd4);
    chk("stream_pc4", pc_out, 32'd4);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    chk("stream_addr8", imem_bus.imem_addr, 32'd8);
    chk("stream_pc8", pc_out, 32'd8);
`ifdef IF_PERF_CNT_EN
    chk("fetch_count2", fetch_count, 32'd2);
    chk("bubble_count0", bubble_count, 32'd0);
`endif

    // Ack under stall goes to the skid; no request while holding.
    cyc(1'b1, 1'b0, 32'd0, 1'b1);
    chk("hold_req", {31'd0, imem_bus.imem_req}, 32'd0);
    cyc(1'b1, 1'b0, 32'd0, 1'b0);
    cyc(1'b1, 1'b0, 32'd0, 1'b0);
    chk("hold_req2", {31'd0, imem_bus.imem_req}, 32'd0);
    cyc(1'b0, 1'b0, 32'd0, 1'b0);
    chk("skid_pc12", pc_out, 32'd12);
    chk("skid_valid", {31'd0, instr_valid}, 32'd1);
    chk("after_skid_addr", imem_bus.imem_addr, 32'd12);

    // Slow memory with a redirect on a wait cycle: old request completes, data dropped.
    cyc(1'b0, 1'b0, 32'd0, 1'b0);
    cyc(1'b0, 1'b1, 32'h100, 1'b0);
    chk("discard_addr_kept", imem_bus.imem_addr, 32'd12);
    cyc(1'b0, 1'b0, 32'd0, 1'b0);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    chk("discard_drop_valid", {31'd0, instr_valid}, 32'd0);
    chk("discard_new_addr", imem_bus.imem_addr, 32'h100);

    // Redirect together with ack.
    cyc(1'b0, 1'b1, 32'h200, 1'b1);
    chk("redir_ack_addr", imem_bus.imem_addr, 32'h200);

    // Misaligned target and address wrap.
    cyc(1'b0, 1'b1, 32'h103, 1'b0);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    chk("aligned_addr", imem_bus.imem_addr, 32'h100);
    cyc(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    chk("wrap_pc", pc_out, 32'd0);
    chk("wrap_addr", imem_bus.imem_addr, 32'd0);

    // Reset while waiting out a wrong-path request.
    cyc(1'b0, 1'b1, 32'h40, 1'b0);
    reset = 1'b1;
    #1;
    chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
    chk("midrst_instr", instr_out, 32'd0);
    chk("midrst_pc", pc_out, 32'd0);
    chk("midrst_req", {31'd0, imem_bus.imem_req}, 32'd0);
`ifdef IF_PERF_CNT_EN
    chk("midrst_fetch_cnt", fetch_count, 32'd0);
    chk("midrst_bubble_cnt", bubble_count, 32'd0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_pc = 32'd0;
    cyc(1'b0, 1'b0, 32'd0, 1'b0);
    chk("post_rst_addr", imem_bus.imem_addr, 32'd0);
    chk("post_rst_req", {31'd0, imem_bus.imem_req}, 32'd1);

    // Randomized traffic: variable latency, stalls and redirects.
    n_deliv = 0;
    lat_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      if (imem_bus.imem_req) begin
        if (lat_cnt == 0) begin
          r_ak = 1'b1;
          lat_cnt = $urandom_range(0, 3);
        end else begin
          r_ak = 1'b0;
          lat_cnt--;
        end
      end else begin
        r_ak = 1'b0;
      end
      r_st = ($urandom_range(0, 3) == 0);
      r_rv = ($urandom_range(0, 11) == 0);
      r_rp = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      cyc(r_st, r_rv, r_rp, r_ak);
    end
    chk("random_progress", {31'd0, (n_deliv > 200)}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
